alu_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared 16-bit ALU. Two requesters (e.g. the execute stage and the address-generation unit) issue ALU operations over independent valid/ready request channels. The block grants one request at a time with round-robin priority, latches the operands, drives the ALU and registers its result and overflow flag. The result returns to the granted requester on a valid/ready response channel with back-pressure.

---
 rtl/alu_arbiter_pkg.sv | 18 +
 rtl/alu_arbiter_alu.sv | 46 ++++
 rtl/alu_arbiter.sv | 110 +++++++++++
 tb/tb_alu_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared ALU op codes and arbiter FSM state encodings.
package alu_arbiter_pkg;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SLL = 3'd5;
    localparam logic [2:0] ALU_SRL = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purpose: combinational 16-bit ALU with signed overflow for ADD/SUB.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the owner registers the outputs.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
#(
    parameter int CPU_WIDTH = 16
) (
    input  logic [CPU_WIDTH-1:0] a,
    input  logic [CPU_WIDTH-1:0] b,
    input  logic [2:0]           op,
    output logic [CPU_WIDTH-1:0] result,
    output logic                 ovf
);

    localparam int MSB = CPU_WIDTH - 1;

    logic [CPU_WIDTH-1:0] sum;
    logic [CPU_WIDTH-1:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    // Shifts use the whole B operand, so any amount >= CPU_WIDTH yields zero.
    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (op)
            ALU_ADD: begin
                result = sum;
                ovf    = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            ALU_SUB: begin
                result = diff;
                ovf    = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLL: result = a << b;
            ALU_SRL: result = a >> b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Purpose: round-robin two-port arbiter/sequencer in front of the shared ALU.
// Latency: request handshake to response valid is 2 cycles; 3-cycle best-case issue interval.
// Backpressure: holds RESP with stable data until the owner takes it; no accepts meanwhile.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int CPU_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [CPU_WIDTH-1:0] req0_a,
    input  logic [CPU_WIDTH-1:0] req0_b,
    input  logic [2:0]           req0_op,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [CPU_WIDTH-1:0] req1_a,
    input  logic [CPU_WIDTH-1:0] req1_b,
    input  logic [2:0]           req1_op,
    output logic                 rsp0_valid,
    input  logic                 rsp0_ready,
    output logic                 rsp1_valid,
    input  logic                 rsp1_ready,
    output logic [CPU_WIDTH-1:0] rsp_data,
    output logic                 rsp_ovf,
    output logic                 busy
);

    arb_state_t           state;
    logic                 last_grant;
    logic                 owner;
    logic [CPU_WIDTH-1:0] op_a;
    logic [CPU_WIDTH-1:0] op_b;
    logic [2:0]           op_code;
    logic [CPU_WIDTH-1:0] alu_result;
    logic                 alu_ovf;
    logic                 sel;
    logic                 accept;
    logic                 rsp_taken;

    // On a tie the requester that did not win last time goes first.
    assign sel        = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    assign req0_ready = (state == IDLE) && req0_valid && !sel;
    assign req1_ready = (state == IDLE) && req1_valid && sel;
    assign accept     = req0_ready || req1_ready;
    assign rsp_taken  = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

    alu_arbiter_alu #(
        .CPU_WIDTH (CPU_WIDTH)
    ) u_alu (
        .a      (op_a),
        .b      (op_b),
        .op     (op_code),
        .result (alu_result),
        .ovf    (alu_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            op_code    <= '0;
            rsp_data   <= '0;
            rsp_ovf    <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a       <= sel ? req1_a  : req0_a;
                        op_b       <= sel ? req1_b  : req0_b;
                        op_code    <= sel ? req1_op : req0_op;
                        owner      <= sel;
                        last_grant <= sel;
                        busy       <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data   <= alu_result;
                    rsp_ovf    <= alu_ovf;
                    rsp0_valid <= !owner;
                    rsp1_valid <= owner;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_taken) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    rsp0_valid <= 1'b0;
                    rsp1_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed-vector bench for alu_arbiter: single ops, overflow, shifts, round-robin, back-pressure, reset abort.
module tb_alu_arbiter;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRL = 3'd6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready;
    logic [15:0] req0_a, req0_b;
    logic [2:0]  req0_op;
    logic        req1_valid, req1_ready;
    logic [15:0] req1_a, req1_b;
    logic [2:0]  req1_op;
    logic        rsp0_valid, rsp0_ready;
    logic        rsp1_valid, rsp1_ready;
    logic [15:0] rsp_data;
    logic        rsp_ovf;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.CPU_WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_data   (rsp_data),
        .rsp_ovf    (rsp_ovf),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int p, input logic v, input logic [15:0] a,
                           input logic [15:0] b, input logic [2:0] op);
        if (p == 0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
        end
    endtask

    task automatic set_rsp_ready(input int p, input logic v);
        if (p == 0) rsp0_ready = v;
        else        rsp1_ready = v;
    endtask

    // Full transaction on one port with the response taken immediately.
    task automatic do_op(input string tag, input int p, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] op, input logic [15:0] exp_d, input logic exp_o);
        @(negedge clk);
        set_req(p, 1'b1, a, b, op);
        #1;
        check({tag, "_ready"}, (p == 0) ? req0_ready : req1_ready, 1);
        @(posedge clk); #1;
        set_req(p, 1'b0, 16'h0, 16'h0, 3'd0);
        check({tag, "_exec_busy"}, busy, 1);
        check({tag, "_exec_novld"}, {rsp1_valid, rsp0_valid}, 0);
        @(posedge clk); #1;
        check({tag, "_vld"}, {rsp1_valid, rsp0_valid}, (p == 0) ? 2'b01 : 2'b10);
        check({tag, "_data"}, rsp_data, exp_d);
        check({tag, "_ovf"}, rsp_ovf, exp_o);
        set_rsp_ready(p, 1'b1);
        @(posedge clk); #1;
        set_rsp_ready(p, 1'b0);
        check({tag, "_idle"}, busy, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        set_req(0, 1'b0, 16'h0, 16'h0, 3'd0);
        set_req(1, 1'b0, 16'h0, 16'h0, 3'd0);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        rst_n      = 1'b0;
        #1;
        check("rst_outputs", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, rsp_ovf}, 0);
        check("rst_data", rsp_data, 16'h0000);
        do_reset();
        #1;
        check("post_rst_busy", busy, 0);

        // Single request and arithmetic vectors
        do_op("add0", 0, 16'h0003, 16'h0004, OP_ADD, 16'h0007, 1'b0);
        do_op("ovf_add", 1, 16'h7FFF, 16'h0001, OP_ADD, 16'h8000, 1'b1);
        do_op("ovf_sub", 1, 16'h8000, 16'h0001, OP_SUB, 16'h7FFF, 1'b1);
        do_op("xor", 1, 16'h8000, 16'h0001, OP_XOR, 16'h8001, 1'b0);
        do_op("sub_neg", 0, 16'h0003, 16'h0005, OP_SUB, 16'hFFFE, 1'b0);
        do_op("sll4", 0, 16'h0001, 16'h0004, OP_SLL, 16'h0010, 1'b0);
        do_op("srl15", 0, 16'h8000, 16'h000F, OP_SRL, 16'h0001, 1'b0);
        do_op("sll16", 0, 16'h0001, 16'h0010, OP_SLL, 16'h0000, 1'b0);
        do_op("and", 1, 16'hF0F0, 16'h0FF0, OP_AND, 16'h00F0, 1'b0);

        // Round-robin from reset: both held valid, grants must alternate 0,1,0,1
        do_reset();
        @(posedge clk); #1;
        set_req(0, 1'b1, 16'h0001, 16'h0001, OP_ADD);
        set_req(1, 1'b1, 16'h000A, 16'h000A, OP_ADD);
        #1;
        for (int i = 0; i < 4; i++) begin
            int g;
            g = i % 2;
            check($sformatf("rr%0d_ready", i), {req1_ready, req0_ready}, (g == 0) ? 2'b01 : 2'b10);
            @(posedge clk); #1;
            check($sformatf("rr%0d_exec_ready", i), {req1_ready, req0_ready}, 0);
            @(posedge clk); #1;
            check($sformatf("rr%0d_vld", i), {rsp1_valid, rsp0_valid}, (g == 0) ? 2'b01 : 2'b10);
            check($sformatf("rr%0d_data", i), rsp_data, (g == 0) ? 16'h0002 : 16'h0014);
            set_rsp_ready(g, 1'b1);
            #1;
            check($sformatf("rr%0d_no_same_cycle", i), {req1_ready, req0_ready}, 0);
            @(posedge clk); #1;
            set_rsp_ready(g, 1'b0);
            #1;
        end
        set_req(0, 1'b0, 16'h0, 16'h0, 3'd0);
        set_req(1, 1'b0, 16'h0, 16'h0, 3'd0);

        // Back-pressure: rsp0 held off while req1 waits
        @(negedge clk);
        set_req(0, 1'b1, 16'hF0F0, 16'h0FF0, OP_AND);
        #1;
        check("bp_req0_ready", req0_ready, 1);
        @(posedge clk); #1;
        set_req(0, 1'b0, 16'h0, 16'h0, 3'd0);
        set_req(1, 1'b1, 16'h1200, 16'h0034, OP_OR);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d_vld", i), {rsp1_valid, rsp0_valid}, 2'b01);
            check($sformatf("bp%0d_data", i), rsp_data, 16'h00F0);
            check($sformatf("bp%0d_req1_ready", i), req1_ready, 0);
            @(posedge clk); #1;
        end
        rsp0_ready = 1'b1;
        #1;
        check("bp_hs_req1_ready", req1_ready, 0);
        @(posedge clk); #1;
        rsp0_ready = 1'b0;
        check("bp_next_idle_req1_ready", req1_ready, 1);
        @(posedge clk); #1;
        set_req(1, 1'b0, 16'h0, 16'h0, 3'd0);
        @(posedge clk); #1;
        check("bp_rsp1_vld", {rsp1_valid, rsp0_valid}, 2'b10);
        check("bp_rsp1_data", rsp_data, 16'h1234);
        rsp1_ready = 1'b1;
        @(posedge clk); #1;
        rsp1_ready = 1'b0;

        // Reset during EXEC: grant to req0 leaves last_grant=0 before the abort
        @(negedge clk);
        set_req(0, 1'b1, 16'h0005, 16'h0006, OP_ADD);
        #1;
        check("mid_req0_ready", req0_ready, 1);
        @(posedge clk); #1;
        set_req(0, 1'b0, 16'h0, 16'h0, 3'd0);
        check("mid_exec_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_outputs", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, rsp_ovf}, 0);
        check("mid_rst_data", rsp_data, 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("mid_no_rsp%0d", i), {rsp1_valid, rsp0_valid, busy}, 0);
        end
        set_req(0, 1'b1, 16'h0001, 16'h0002, OP_ADD);
        set_req(1, 1'b1, 16'h0003, 16'h0004, OP_ADD);
        #1;
        check("mid_tie_grant", {req1_ready, req0_ready}, 2'b01);
        @(posedge clk); #1;
        set_req(0, 1'b0, 16'h0, 16'h0, 3'd0);
        set_req(1, 1'b0, 16'h0, 16'h0, 3'd0);
        @(posedge clk); #1;
        check("mid_tie_rsp", {rsp1_valid, rsp0_valid}, 2'b01);
        check("mid_tie_data", rsp_data, 16'h0003);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
